serial_word_receiver: RTL and testbench

//   Serial-in/parallel-out receiver for the serial bit adder datapath. It collects
//   an LSB-first bit stream, one bit per qualified cycle, into a WIDTH-bit word.
//   It is the counterpart of the parallel-load right-shift register that feeds the

---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_word_receiver_if.sv | 29 ++
 rtl/sipo_shift_core.sv | 43 ++++
 rtl/serial_word_receiver.sv | 90 +++++++++
 tb/tb_serial_word_receiver.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the serial bit adder datapath.
// Used by both the receiver and the transmitter shift register.
package serial_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam int SER_WIDTH = 8;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_t;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Serial input / parallel word output bundle.
// The master drives the stream and accepts words; the slave is the receiver.
interface serial_word_receiver_if
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
);

    logic             start;
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             word_done;
    logic             overrun;

    modport master (
        output start, sin, sin_valid, out_ready,
        input  out_data, out_valid, busy, word_done, overrun
    );

    modport slave (
        input  start, sin, sin_valid, out_ready,
        output out_data, out_valid, busy, word_done, overrun
    );

endinterface

// File: rtl/sipo_shift_core.sv
// LSB-first serial-to-parallel shifter with bit counter.
// Only WIDTH-1 bits are stored; the last bit comes straight from sin.
module sipo_shift_core
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift,
    input  logic             sin,
    output logic [WIDTH-1:0] word,
    output logic             complete
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-2:0] shreg;
    logic [CW-1:0]    bitcnt;

    assign word     = {sin, shreg};
    assign complete = shift && (bitcnt == LAST);

    // clear wins over a shift, so sin is dropped on a plain restart
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else begin
            if (clr)
                shreg <= '0;
            else if (shift)
                shreg <= word[WIDTH-1:1];
            if (clr || complete)
                bitcnt <= '0;
            else if (shift)
                bitcnt <= bitcnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial word receiver: FSM plus a holding register with
// a valid/ready handshake and a sticky overrun flag.
module serial_word_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_word_receiver_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             orun_q, orun_d;
    logic             complete;
    logic             shift_en;

    assign shift_en = (state_q == SHIFT) && bus.sin_valid;

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.start),
        .shift    (shift_en),
        .sin      (bus.sin),
        .word     (word),
        .complete (complete)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            orun_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            orun_q  <= orun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        orun_d  = orun_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    orun_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (complete && !bus.start)
                    state_d = IDLE;
            end
        endcase
        // a completing word may replace one being accepted this cycle
        if (complete) begin
            if (!valid_q || bus.out_ready) begin
                data_d  = word;
                valid_d = 1'b1;
                done_d  = 1'b1;
            end else begin
                orun_d = 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.word_done = done_q;
    assign bus.overrun   = orun_q;
    assign bus.busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver (WIDTH 8 and 16).
// Expected words are queued at send time and popped on word_done.
module tb_serial_word_receiver;

    logic clk;
    logic rst;

    serial_word_receiver_if #(.WIDTH(8))  bus8();
    serial_word_receiver_if #(.WIDTH(16)) bus16();

    serial_word_receiver #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_word_receiver #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec = 0;
    int mis = 0;
    int done8 = 0;
    int done16 = 0;
    logic [7:0]  q8[$];
    logic [15:0] q16[$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus8.word_done) begin
            done8++;
            if (q8.size() == 0)
                chk("sb8_extra", 32'(q8.size()), 32'd1);
            else
                chk("sb8_data", 32'(bus8.out_data), 32'(q8.pop_front()));
        end
        if (!rst && bus16.word_done) begin
            done16++;
            if (q16.size() == 0)
                chk("sb16_extra", 32'(q16.size()), 32'd1);
            else
                chk("sb16_data", 32'(bus16.out_data), 32'(q16.pop_front()));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_word;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
    endtask

    task automatic shift8(input logic [7:0] w,
                          input int n,
                          input int gap_at,
                          input int gap_len,
                          input logic start_last,
                          input logic rdy_last);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus8.sin = ~w[i];
                    bus8.sin_valid = 1'b0;
                    tick();
                    chk("gap_busy", 32'(bus8.busy), 32'd1);
                end
            end
            bus8.sin = w[i];
            bus8.sin_valid = 1'b1;
            if (i == 7) begin
                bus8.start = start_last;
                bus8.out_ready = rdy_last;
            end
            tick();
            if (i != 7)
                chk("shift_busy", 32'(bus8.busy), 32'd1);
        end
        bus8.sin_valid = 1'b0;
        bus8.start = 1'b0;
        bus8.out_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data"},  32'(bus8.out_data),  32'd0);
        chk({tag, "_valid"}, 32'(bus8.out_valid), 32'd0);
        chk({tag, "_busy"},  32'(bus8.busy),      32'd0);
        chk({tag, "_done"},  32'(bus8.word_done), 32'd0);
        chk({tag, "_orun"},  32'(bus8.overrun),   32'd0);
    endtask

    task automatic consume8;
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        chk("consume", 32'(bus8.out_valid), 32'd0);
    endtask

    int d;

    initial begin
        rst = 1'b1;
        bus8.start = 1'b0;
        bus8.sin = 1'b0;
        bus8.sin_valid = 1'b0;
        bus8.out_ready = 1'b0;
        bus16.start = 1'b0;
        bus16.sin = 1'b0;
        bus16.sin_valid = 1'b0;
        bus16.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_zero("reset");

        // basic word
        begin_word();
        chk("t1_busy_on", 32'(bus8.busy), 32'd1);
        q8.push_back(8'hA5);
        shift8(8'hA5, 8, -1, 0, 1'b0, 1'b0);
        chk("t1_valid", 32'(bus8.out_valid), 32'd1);
        chk("t1_done", 32'(bus8.word_done), 32'd1);
        chk("t1_data", 32'(bus8.out_data), 32'hA5);
        tick();
        chk("t1_busy_off", 32'(bus8.busy), 32'd0);
        chk("t1_pulse", 32'(bus8.word_done), 32'd0);
        chk("t1_hold", 32'(bus8.out_valid), 32'd1);
        consume8();

        // gapped stream
        begin_word();
        q8.push_back(8'h3C);
        shift8(8'h3C, 8, 4, 3, 1'b0, 1'b0);
        chk("t2_data", 32'(bus8.out_data), 32'h3C);
        consume8();

        // overrun
        begin_word();
        q8.push_back(8'h11);
        shift8(8'h11, 8, -1, 0, 1'b0, 1'b0);
        tick();
        d = done8;
        begin_word();
        shift8(8'h22, 8, -1, 0, 1'b0, 1'b0);
        chk("t3_data", 32'(bus8.out_data), 32'h11);
        chk("t3_orun", 32'(bus8.overrun), 32'd1);
        chk("t3_done", 32'(bus8.word_done), 32'd0);
        chk("t3_valid", 32'(bus8.out_valid), 32'd1);
        tick();
        chk("t3_no_done", 32'(done8), 32'(d));
        begin_word();
        chk("t3_orun_clr", 32'(bus8.overrun), 32'd0);
        consume8();

        // back-to-back, already in SHIFT
        q8.push_back(8'h81);
        shift8(8'h81, 8, -1, 0, 1'b1, 1'b0);
        chk("t4_busy", 32'(bus8.busy), 32'd1);
        chk("t4_data1", 32'(bus8.out_data), 32'h81);
        q8.push_back(8'h7E);
        shift8(8'h7E, 8, -1, 0, 1'b0, 1'b1);
        chk("t4_data2", 32'(bus8.out_data), 32'h7E);
        chk("t4_done2", 32'(bus8.word_done), 32'd1);
        chk("t4_orun", 32'(bus8.overrun), 32'd0);
        tick();
        chk("t4_idle", 32'(bus8.busy), 32'd0);
        consume8();

        // restart mid-word
        begin_word();
        shift8(8'hFF, 5, -1, 0, 1'b0, 1'b0);
        bus8.start = 1'b1;
        bus8.sin = 1'b1;
        bus8.sin_valid = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.sin_valid = 1'b0;
        chk("t5_busy", 32'(bus8.busy), 32'd1);
        q8.push_back(8'h0F);
        shift8(8'h0F, 8, -1, 0, 1'b0, 1'b0);
        chk("t5_data", 32'(bus8.out_data), 32'h0F);

        // reset mid-word with a word still held
        begin_word();
        shift8(8'hFF, 3, -1, 0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("t5_rst");

        // 16-bit instance
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        q16.push_back(16'hBEEF);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = 16'hBEEF;
            bus16.sin = w[i];
            bus16.sin_valid = 1'b1;
            tick();
            if (i == 14) begin
                chk("t6_early_done", 32'(bus16.word_done), 32'd0);
                chk("t6_early_valid", 32'(bus16.out_valid), 32'd0);
            end
        end
        bus16.sin_valid = 1'b0;
        chk("t6_done", 32'(bus16.word_done), 32'd1);
        chk("t6_data", 32'(bus16.out_data), 32'hBEEF);

        tick();
        tick();
        chk("sb8_left", 32'(q8.size()), 32'd0);
        chk("sb16_left", 32'(q16.size()), 32'd0);
        chk("done16_cnt", 32'(done16), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
